// File: rtl/mem_access_if.sv
// Request/response and datamem bus of the memory-stage load/store unit.
// slave: load/store unit side; master: pipeline + datamem side.
interface mem_access_if #(
  parameter int ADDR_W = 32,
  parameter int IW     = 7
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_we;
  logic [IW-1:0]     mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size,
    input  req_signed, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output resp_err, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size,
    output req_signed, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_err, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: byte/half/word requests -> word datamem
// accesses, sub-word stores as read-modify-write, one-cycle response.
// Ports: clk, reset_n (async, active-low), bus (mem_access_if.slave):
//   req_* handshake in, resp_* pulse out, mem_* to combinational datamem.
// Macro MISALIGN_TRAP_EN: misaligned half/word -> error instead of masking.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 128
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_access_if.slave  bus
);
  localparam int IW   = $clog2(DEPTH);
  localparam int HI_W = ADDR_W - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  state_t        r_state;
  logic          r_ready;
  logic          r_write;
  logic [1:0]    r_size;
  logic          r_signed;
  logic [1:0]    r_lane;
  logic [15:0]   r_wdata;
  logic          r_resp_valid;
  logic [31:0]   r_resp_rdata;
  logic          r_resp_err;
  logic          r_we;
  logic [IW-1:0] r_maddr;
  logic [31:0]   r_mwdata;

  logic [HI_W-1:0] w_hi;
  logic [IW-1:0]   w_idx;
  logic            w_range;
  logic            w_mis;
  logic            w_err;
  logic            w_word_st;
  logic [31:0]     w_shift;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_ldata;
  logic [31:0]     w_merged;

  assign w_hi    = bus.req_addr[ADDR_W-1:2];
  assign w_idx   = bus.req_addr[IW+1:2];
  assign w_range = (w_hi >= HI_W'(DEPTH));

`ifdef MISALIGN_TRAP_EN
  assign w_mis = ((bus.req_size == 2'b01) && bus.req_addr[0])
              || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
  // Misaligned accesses simply drop the low address bits.
  assign w_mis = 1'b0;
`endif

  assign w_err = w_range || w_mis || (bus.req_size == 2'b11);
  assign w_word_st = !w_err && bus.req_write
                  && (bus.req_size == 2'b10);

  // Lane extraction and merge both work on the live READ word.
  always_comb begin
    w_shift  = bus.mem_rdata >> {r_lane, 3'b000};
    w_byte   = w_shift[7:0];
    w_half   = r_lane[1] ? bus.mem_rdata[31:16]
                         : bus.mem_rdata[15:0];
    w_ldata  = bus.mem_rdata;
    w_merged = bus.mem_rdata;
    case (r_size)
      2'b00: begin
        w_ldata = r_signed ? {{24{w_byte[7]}}, w_byte}
                           : {24'b0, w_byte};
        w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
      end
      2'b01: begin
        w_ldata = r_signed ? {{16{w_half[15]}}, w_half}
                           : {16'b0, w_half};
        if (r_lane[1]) w_merged[31:16] = r_wdata;
        else           w_merged[15:0]  = r_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b0;
      r_write      <= 1'b0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_lane       <= 2'b00;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_we         <= 1'b0;
      r_maddr      <= '0;
      r_mwdata     <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_we         <= 1'b0;
      r_maddr      <= '0;
      r_mwdata     <= '0;
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (bus.req_valid && r_ready) begin
            r_ready  <= 1'b0;
            r_write  <= bus.req_write;
            r_size   <= bus.req_size;
            r_signed <= bus.req_signed;
            r_lane   <= bus.req_addr[1:0];
            r_wdata  <= bus.req_wdata[15:0];
            unique case (1'b1)
              w_err: begin
                r_state      <= S_RESP;
                r_resp_valid <= 1'b1;
                r_resp_err   <= 1'b1;
              end
              w_word_st: begin
                r_state  <= S_WRITE;
                r_we     <= 1'b1;
                r_maddr  <= w_idx;
                r_mwdata <= bus.req_wdata;
              end
              default: begin
                r_state <= S_READ;
                r_maddr <= w_idx;
              end
            endcase
          end
        end
        S_READ: begin
          if (r_write) begin
            r_state  <= S_WRITE;
            r_we     <= 1'b1;
            r_maddr  <= r_maddr;
            r_mwdata <= w_merged;
          end else begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_ldata;
          end
        end
        S_WRITE: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.mem_we     = r_we;
  assign bus.mem_addr   = r_maddr;
  assign bus.mem_wdata  = r_mwdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a response scoreboard
// and a behavioural 128-word datamem.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_if #(.ADDR_W(32), .IW(7)) bus ();

  mem_access_unit #(.ADDR_W(32), .DEPTH(128)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [31:0] mem [128] = '{default: 32'h0};
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk)
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  int we_cnt = 0;
  always @(posedge clk) if (bus.mem_we) we_cnt++;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  // Monitor: pops expectation for every response pulse.
  always @(negedge clk) begin
    if (reset_n && bus.resp_valid) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL resp_unexpected: got err=%0b rdata=%08h want none",
                 bus.resp_err, bus.resp_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.resp_err !== e.err || bus.resp_rdata !== e.rdata) begin
          n_bad++;
          $display("FAIL resp: got err=%0b rdata=%08h want err=%0b rdata=%08h",
                   bus.resp_err, bus.resp_rdata, e.err, e.rdata);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; on return we are #1 into cycle T+1.
  task automatic issue(input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] ad,
                       input logic [31:0] wd, input logic push,
                       input logic ee, input logic [31:0] er);
    int n;
    exp_t e;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      step();
      n++;
    end
    chk("ready_wait", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = ad;
    bus.req_wdata  = wd;
    if (push) begin
      e.err = ee;
      e.rdata = er;
      sb.push_back(e);
    end
    step();
    bus.req_valid = 1'b0;
  endtask

  int wc;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    // 1: reset state
    #23;
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
    chk("rst_ready", {31'b0, bus.req_ready}, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("ready_before_clk", {31'b0, bus.req_ready}, 32'd0);
    step();
    chk("ready_after_clk", {31'b0, bus.req_ready}, 32'd1);

    // word store
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
    chk("ws_t1_we", {31'b0, bus.mem_we}, 32'd1);
    chk("ws_t1_addr", {25'b0, bus.mem_addr}, 32'd4);
    chk("ws_t1_wdata", bus.mem_wdata, 32'hDEADBEEF);
    step();
    chk("ws_t2_valid", {31'b0, bus.resp_valid}, 32'd1);
    chk("ws_t2_we", {31'b0, bus.mem_we}, 32'd0);

    // 2: byte store read-modify-write
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5, 1'b1, 1'b0, 32'h0);
    chk("bs_t1_we", {31'b0, bus.mem_we}, 32'd0);
    chk("bs_t1_addr", {25'b0, bus.mem_addr}, 32'd4);
    step();
    chk("bs_t2_we", {31'b0, bus.mem_we}, 32'd1);
    chk("bs_t2_wdata", bus.mem_wdata, 32'hDEADA5EF);
    step();
    chk("bs_t3_valid", {31'b0, bus.resp_valid}, 32'd1);

    // half store upper lane into idx 6: 0 -> 12340000
    issue(1'b1, 2'b01, 1'b0, 32'h1A, 32'hFFFF1234, 1'b1, 1'b0, 32'h0);
    step();
    chk("hs_t2_wdata", bus.mem_wdata, 32'h12340000);
    step();

    // 3: loads
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b1, 1'b0, 32'hFFFFFFDE);
    step();
    chk("lb_t2_valid", {31'b0, bus.resp_valid}, 32'd1);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1, 1'b0, 32'h0000DEAD);
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 32'hFFFFA5EF);
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b1, 1'b0, 32'h000000A5);
    issue(1'b0, 2'b10, 1'b1, 32'h18, 32'h0, 1'b1, 1'b0, 32'h12340000);

    // 4: misaligned word load
`ifdef MISALIGN_TRAP_EN
    issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b1, 1'b1, 32'h0);
    chk("mis_t1_valid", {31'b0, bus.resp_valid}, 32'd1);
    chk("mis_t1_we", {31'b0, bus.mem_we}, 32'd0);
`else
    issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b1, 1'b0, 32'hDEADA5EF);
    chk("mis_t1_addr", {25'b0, bus.mem_addr}, 32'd4);
`endif
    step();

    // 5: error paths, no writes
    wc = we_cnt;
    issue(1'b1, 2'b10, 1'b0, 32'h200, 32'h11111111, 1'b1, 1'b1, 32'h0);
    chk("oor_t1_valid", {31'b0, bus.resp_valid}, 32'd1);
    step();
    issue(1'b1, 2'b11, 1'b0, 32'h20, 32'h22222222, 1'b1, 1'b1, 32'h0);
    step();
    issue(1'b0, 2'b10, 1'b0, 32'h1FC, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    step();
    chk("err_no_we", we_cnt, wc);
    chk("err_mem8", mem[8], 32'h0);

    // 6: reset during READ of a sub-word store
    wc = we_cnt;
    issue(1'b1, 2'b00, 1'b0, 32'h14, 32'h00000077, 1'b0, 1'b0, 32'h0);
    reset_n = 1'b0;
    #1;
    chk("abort_addr", {25'b0, bus.mem_addr}, 32'd0);
    chk("abort_we", {31'b0, bus.mem_we}, 32'd0);
    chk("abort_ready", {31'b0, bus.req_ready}, 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    chk("abort_ready_after", {31'b0, bus.req_ready}, 32'd1);
    chk("abort_no_we", we_cnt, wc);
    chk("abort_mem5", mem[5], 32'h0);

    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEADA5EF);
    step();
    step();
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
